// File: rtl/baud_gen.sv
// Baud-rate generator: oversample strobe, bit strobe and 50% square clock,
// with a 4-entry divisor table, req/ack reconfiguration, enable and resync.
module baud_gen #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD0      = 9600,
    parameter int unsigned BAUD1      = 19200,
    parameter int unsigned BAUD2      = 57600,
    parameter int unsigned BAUD3      = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_req,
    input  logic [1:0]       speed,
    input  logic             resync,
    output logic             cfg_ack,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             clk_out,
    output logic [CNT_W-1:0] div_val
);

    localparam int unsigned SUB_W = (OVERSAMPLE >= 2) ? $clog2(OVERSAMPLE) : 1;

    // Rounded-to-nearest divisor; a zero denominator yields 0 so the range check trips.
    function automatic logic [63:0] calc_div(input logic [63:0] baud);
        logic [63:0] den;
        den = baud * 64'(OVERSAMPLE);
        if (den == 64'd0) begin
            return 64'd0;
        end
        return (64'(CLK_HZ) + den / 64'd2) / den;
    endfunction

    localparam logic [63:0] DIV0_L = calc_div(64'(BAUD0));
    localparam logic [63:0] DIV1_L = calc_div(64'(BAUD1));
    localparam logic [63:0] DIV2_L = calc_div(64'(BAUD2));
    localparam logic [63:0] DIV3_L = calc_div(64'(BAUD3));

    // Speed slot to divisor; used both for elaboration checks and the LOAD mux.
    function automatic logic [63:0] div_of(input logic [1:0] k);
        case (k)
            2'd0:    return DIV0_L;
            2'd1:    return DIV1_L;
            2'd2:    return DIV2_L;
            default: return DIV3_L;
        endcase
    endfunction

    generate
        if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("baud_gen: OVERSAMPLE must be even and >= 2");
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_div_chk
            if (div_of(2'(gi)) < 64'd2 || div_of(2'(gi)) >= (64'd1 << CNT_W)) begin : g_bad_div
                $error("baud_gen: divisor out of range for a speed slot");
            end
        end
    endgenerate

    typedef enum logic [0:0] {ST_RUN, ST_LOAD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       spd_q, spd_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic             clk_q, clk_d;
    logic             os_tick_q, os_tick_d;
    logic             baud_tick_q, baud_tick_d;
    logic             ack_q, ack_d;

    logic os_wrap;
    logic sub_last;
    logic sub_half;

    assign os_wrap  = (os_cnt_q == div_q - CNT_W'(1));
    assign sub_last = (sub_cnt_q == SUB_W'(OVERSAMPLE - 1));
    assign sub_half = (sub_cnt_q == SUB_W'(OVERSAMPLE / 2 - 1));

    // Next-state and datapath: reconfiguration has priority over resync,
    // resync has priority over counting, and ticks default low.
    always_comb begin
        state_d     = state_q;
        spd_d       = spd_q;
        div_d       = div_q;
        os_cnt_d    = os_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        clk_d       = clk_q;
        os_tick_d   = 1'b0;
        baud_tick_d = 1'b0;
        ack_d       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_req) begin
                    spd_d   = speed;
                    state_d = ST_LOAD;
                end
                if (resync && !cfg_req) begin
                    os_cnt_d  = '0;
                    sub_cnt_d = '0;
                    clk_d     = 1'b0;
                end else if (enable) begin
                    if (os_wrap) begin
                        os_cnt_d  = '0;
                        os_tick_d = 1'b1;
                        if (sub_last) begin
                            sub_cnt_d   = '0;
                            baud_tick_d = 1'b1;
                        end else begin
                            sub_cnt_d = sub_cnt_q + SUB_W'(1);
                        end
                        if (sub_half || sub_last) begin
                            clk_d = ~clk_q;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                div_d     = CNT_W'(div_of(spd_q));
                os_cnt_d  = '0;
                sub_cnt_d = '0;
                clk_d     = 1'b0;
                ack_d     = 1'b1;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and latched speed; a reset discards any pending speed.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            spd_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            spd_q   <= spd_d;
        end
    end

    // Divisor, counters and registered strobes.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= CNT_W'(DIV0_L);
            os_cnt_q    <= '0;
            sub_cnt_q   <= '0;
            clk_q       <= 1'b0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            os_cnt_q    <= os_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            clk_q       <= clk_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
            ack_q       <= ack_d;
        end
    end

    assign cfg_ack   = ack_q;
    assign os_tick   = os_tick_q;
    assign baud_tick = baud_tick_q;
    assign clk_out   = clk_q;
    assign div_val   = div_q;

endmodule

// File: doc/baud_gen.md
Name: baud_gen

Overview:
Parametrised baud-rate generator, successor to the fixed 4-speed clock divider. Produces a one-cycle oversample strobe, a one-cycle bit strobe and a 50% square clock for the serial TX/RX path. Run-time speed select comes from a 4-entry divisor table computed at elaboration from CLK_HZ and per-slot baud rates. Adds a req/ack reconfiguration handshake, an enable, and a phase-resync input for RX start-bit alignment.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BAUD0, 9600, baud rate for speed 2'b00
BAUD1, 19200, baud rate for speed 2'b01
BAUD2, 57600, baud rate for speed 2'b10
BAUD3, 115200, baud rate for speed 2'b11
OVERSAMPLE, 16, os_tick pulses per bit; even, >=2
CNT_W, 16, width of divisor and oversample counter

Ports:
clk_in  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = generate ticks; 0 = freeze counters
cfg_req  in  1  single-cycle request to load new speed
speed  in  2  speed select, sampled only with cfg_req
resync  in  1  single-cycle phase realignment
cfg_ack  out  1  one-cycle pulse when new divisor is active
os_tick  out  1  one-cycle oversample strobe
baud_tick  out  1  one-cycle bit strobe
clk_out  out  1  square wave at selected baud rate
div_val  out  CNT_W  divisor currently in use

Behaviour:
- Clock and reset: one clock (clk_in). Reset is asynchronous and active-low (rst_n).
- Divisor table, fixed at elaboration: DIVk = (CLK_HZ + BAUDk*OVERSAMPLE/2) / (BAUDk*OVERSAMPLE), i.e. rounded to nearest. Each DIVk must be >=2 and < 2^CNT_W. OVERSAMPLE must be even and >=2. Any violation is an elaboration error.
- Reset (rst_n low, async):
  - state=RUN, div_val=DIV0.
  - os_cnt=0, sub_cnt=0.
  - clk_out=0, os_tick=0, baud_tick=0, cfg_ack=0.
- FSM states:
  - RUN: normal counting. cfg_req=1 latches speed into spd_q and moves to LOAD next cycle.
  - LOAD: div_val<=DIV[spd_q], os_cnt<=0, sub_cnt<=0, clk_out<=0, cfg_ack<=1. Returns to RUN.
  - cfg_ack is high exactly the cycle after LOAD.
  - cfg_req in LOAD is ignored. It is not queued.
- Counting, in RUN with enable=1:
  - os_cnt counts 0..div_val-1 and wraps.
  - os_tick is registered: high for 1 cycle when os_cnt==div_val-1.
  - On each os_tick, sub_cnt counts 0..OVERSAMPLE-1 and wraps.
  - baud_tick is high in the same cycle as the os_tick where sub_cnt wraps from OVERSAMPLE-1.
  - clk_out toggles on os_tick when sub_cnt==OVERSAMPLE/2-1 and when sub_cnt==OVERSAMPLE-1. Period is exactly div_val*OVERSAMPLE cycles, duty 50%.
- First tick timing: after reset or LOAD, the first os_tick comes div_val cycles after counting resumes. The first baud_tick comes div_val*OVERSAMPLE cycles after.
- enable=0: os_cnt, sub_cnt and clk_out hold. os_tick=baud_tick=0. cfg_req is still honoured.
- resync=1 in RUN: next cycle os_cnt=0, sub_cnt=0, clk_out=0, no ticks that cycle. Acts regardless of enable.
- Simultaneous events:
  - resync with cfg_req: cfg_req wins, since LOAD clears the counters anyway.
  - cfg_req while enable=0: LOAD still executes.
- Reset mid-LOAD: the pending speed is discarded and div_val returns to DIV0.
- div_val changes only in LOAD or reset. A speed change without cfg_req has no effect.

Test Plan:
- Defaults: reset, enable=1, no cfg_req -> div_val=326. os_tick every 326 cycles. baud_tick and clk_out period 5216 cycles. clk_out high 2608 cycles. Exactly one baud_tick per 16 os_ticks.
- cfg_req with speed=2'b11 in cycle N -> cfg_ack=1 in cycle N+2 only. div_val=27. First os_tick 27 cycles after resuming. baud period 432 cycles. Repeat with speed 2'b01 -> div_val=163, and 2'b10 -> div_val=54.
- enable dropped for 100 cycles mid-bit -> no ticks during the gap. The next os_tick is delayed by exactly 100 cycles and clk_out level is held.
- resync pulse at os_cnt=200 on default speed -> counters cleared. Next os_tick 326 cycles after the resync-clear cycle. clk_out=0.
- cfg_req in RUN followed by cfg_req in LOAD (speed differs) -> second request ignored. Single cfg_ack, and div_val reflects the first request.
- rst_n asserted asynchronously between clock edges during LOAD -> all outputs 0 immediately and div_val=326. Small-parameter build (CLK_HZ=1600, BAUD0=100, OVERSAMPLE=4) -> div_val=4, baud period 16 cycles.
